// File: rtl/ether_rx.sv
// ether_rx: RMII receive front end; strips preamble/SFD and forwards the frame body as a valid-qualified dibit stream
module ether_rx #(
  parameter int MIN_PRE    = 8,
  parameter int MAX_DIBITS = 6096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       crsdv,
  input  logic [1:0] rxd,
  output logic       axiov,
  output logic [1:0] axiod,
  output logic       done,
  output logic       err
);
  localparam int DW = $clog2(MAX_DIBITS + 1);
  localparam logic [DW-1:0] MAXD = DW'(MAX_DIBITS);
  typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;
  state_t r_state, w_state;
  logic [4:0] r_pre, w_pre;
  logic [DW-1:0] r_dib, w_dib;
  logic r_v, r_done, r_err, w_v, w_done, w_err;
  logic [1:0] r_d, w_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_pre   <= '0;
      r_dib   <= '0;
      r_v     <= 1'b0;
      r_d     <= 2'b00;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_pre   <= w_pre;
      r_dib   <= w_dib;
      r_v     <= w_v;
      r_d     <= w_d;
      r_done  <= w_done;
      r_err   <= w_err;
    end
  always_comb begin
    w_state = r_state;
    w_pre   = r_pre;
    w_dib   = r_dib;
    w_v     = 1'b0;
    w_d     = 2'b00;
    w_done  = 1'b0;
    w_err   = 1'b0;
    case (r_state)
      IDLE: if (crsdv && rxd == 2'b01) begin
        w_state = PRE;
        w_pre   = 5'd1;
      end
      PRE:
        if (!crsdv) w_state = IDLE;
        else if (rxd == 2'b01) w_pre = (r_pre == 5'd31) ? r_pre : r_pre + 5'd1;
        else if (rxd == 2'b11 && r_pre >= 5'(MIN_PRE)) begin
          w_state = DATA;
          w_dib   = '0;
        end else w_state = DROP;
      DATA:
        if (!crsdv) begin
          w_state = IDLE;
          w_done  = 1'b1;
          w_err   = |r_dib[1:0];
        end else if (r_dib == MAXD) begin
          w_state = DROP;
          w_done  = 1'b1;
          w_err   = 1'b1;
        end else begin
          w_v   = 1'b1;
          w_d   = rxd;
          w_dib = r_dib + 1'b1;
        end
      DROP: if (!crsdv) w_state = IDLE;
    endcase
  end
  assign axiov = r_v;
  assign axiod = r_d;
  assign done  = r_done;
  assign err   = r_err;
endmodule

// File: tb/tb_ether_rx.sv
// tb_ether_rx: randomized frame-level check of ether_rx (default and MAX_DIBITS=16 instances) against a frame outcome model
module tb_ether_rx;
  logic clk = 1'b0, rst_n = 1'b0, crsdv = 1'b0;
  logic [1:0] rxd = 2'b00;
  logic [1:0] w_v, w_done, w_err, w_d0, w_d1;
  int n_chk = 0, n_fail = 0, cyc = 0;
  logic [1:0] q0[$], q1[$];
  int cap_dn[2], cap_er[2], cap_dcyc[2], cap_ovl[2];
  ether_rx u_dut (.clk(clk), .rst_n(rst_n), .crsdv(crsdv), .rxd(rxd),
    .axiov(w_v[0]), .axiod(w_d0), .done(w_done[0]), .err(w_err[0]));
  ether_rx #(.MAX_DIBITS(16)) u_ovf (.clk(clk), .rst_n(rst_n), .crsdv(crsdv), .rxd(rxd),
    .axiov(w_v[1]), .axiod(w_d1), .done(w_done[1]), .err(w_err[1]));
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (w_v[0]) q0.push_back(w_d0);
    if (w_v[1]) q1.push_back(w_d1);
    for (int i = 0; i < 2; i++) begin
      if (w_done[i]) begin
        cap_dn[i]++;
        cap_er[i] += int'(w_err[i]);
        cap_dcyc[i] = cyc;
        cap_ovl[i] += int'(w_v[i]);
      end
      if (w_err[i] && !w_done[i]) cap_ovl[i]++;
    end
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic int mn(input int a, input int b);
    return a < b ? a : b;
  endfunction
  task automatic drive(input logic c, input logic [1:0] d);
    crsdv = c;
    rxd = d;
    @(negedge clk);
  endtask
  task automatic run_frame(input int npre, input bit bad, input int len, input int rst_at, input bit fcs, input int gap);
    logic [1:0] body[$], q[$];
    logic [31:0] f = 32'h1a3a_ccb2;
    int b0, mx, fwd, en, k2;
    bit ok, edn, eer;
    for (int k = 0; k < len; k++) begin
      k2 = int'($urandom_range(0, 2));
      body.push_back((rst_at >= 0 && k >= rst_at) ? (k2 == 0 ? 2'b00 : k2 == 1 ? 2'b10 : 2'b11) : 2'($urandom));
    end
    if (fcs) for (int j = 0; j < 16; j++) body[len - 16 + j] = f[31 - 2*j -: 2];
    q0.delete();
    q1.delete();
    for (int i = 0; i < 2; i++) begin
      cap_dn[i] = 0; cap_er[i] = 0; cap_dcyc[i] = 0; cap_ovl[i] = 0;
    end
    repeat ($urandom_range(0, 2)) begin
      k2 = int'($urandom_range(0, 2));
      drive(1'b1, k2 == 0 ? 2'b00 : k2 == 1 ? 2'b10 : 2'b11);
    end
    repeat (npre) drive(1'b1, 2'b01);
    if (bad) drive(1'b1, $urandom_range(0, 1) ? 2'b00 : 2'b10);
    drive(1'b1, 2'b11);
    b0 = cyc;
    for (int k = 0; k < len; k++)
      if (k == rst_at) begin
        rst_n = 1'b0;
        crsdv = 1'b1;
        rxd = body[k];
        #1;
        check("rst_axiov[0]", 32'(w_v[0]), 0);
        check("rst_axiov[1]", 32'(w_v[1]), 0);
        @(negedge clk);
        rst_n = 1'b1;
      end else drive(1'b1, body[k]);
    drive(1'b0, 2'b00);
    #1;
    for (int i = 0; i < 2; i++) begin
      mx = i ? 16 : 6096;
      ok = !bad && npre >= 8;
      fwd = rst_at >= 0 ? rst_at : len;
      en = ok ? mn(fwd, mx) : 0;
      edn = ok && rst_at < 0;
      eer = edn && (len > mx || len % 4 != 0);
      if (i == 0) q = q0; else q = q1;
      check($sformatf("n_valid[%0d]", i), q.size(), en);
      for (int k = 0; k < mn(q.size(), en); k++) check($sformatf("dibit%0d[%0d]", k, i), 32'(q[k]), 32'(body[k]));
      check($sformatf("done_cnt[%0d]", i), cap_dn[i], 32'(edn));
      check($sformatf("err[%0d]", i), cap_er[i], 32'(eer));
      if (edn) check($sformatf("done_cyc[%0d]", i), cap_dcyc[i], b0 + mn(len, mx) + 1);
      check($sformatf("overlap[%0d]", i), cap_ovl[i], 0);
    end
    repeat (gap) @(negedge clk);
  endtask
  initial begin
    #5;
    for (int i = 0; i < 2; i++) begin
      check("rst_axiov", 32'(w_v[i]), 0);
      check("rst_done", 32'(w_done[i]), 0);
      check("rst_err", 32'(w_err[i]), 0);
    end
    check("rst_axiod0", 32'(w_d0), 0);
    check("rst_axiod1", 32'(w_d1), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_frame(31, 0, 100, -1, 1, 2);
    run_frame(4, 0, 8, -1, 0, 1);
    run_frame(10, 1, 8, -1, 0, 0);
    run_frame(12, 0, 24, -1, 0, 1);
    run_frame(9, 0, 7, -1, 0, 1);
    run_frame(8, 0, 20, -1, 0, 1);
    run_frame(8, 0, 16, -1, 0, 1);
    run_frame(7, 0, 12, -1, 0, 1);
    run_frame(10, 0, 0, -1, 0, 1);
    run_frame(16, 0, 30, 10, 0, 2);
    run_frame(20, 0, 12, -1, 0, 0);
    run_frame(20, 0, 12, -1, 0, 0);
    run_frame(35, 0, 40, -1, 0, 0);
    for (int n = 0; n < 40; n++)
      run_frame(int'($urandom_range(1, 35)), $urandom_range(0, 7) == 0, int'($urandom_range(0, 1) ? $urandom_range(0, 24) : $urandom_range(0, 120)), -1, 0, int'($urandom_range(0, 3)));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL timeout: got %0d cycles expected completion", cyc);
    $fatal(1, "timeout");
  end
endmodule
